// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Fixed-priority (video > CPU > loader) arbiter for the shared RAM
//            port, with loader anti-starvation and a req/ack handshake.
// Options  : `define ARB_WP_EN blocks CPU writes below WP_TOP while wp=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int            AW      = 18,
  parameter int            LATENCY = 1,
  parameter int            STARVE  = 16,
  parameter logic [AW-1:0] WP_TOP  = AW'(18'h04000)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vreq,
  input  logic [AW-1:0] va,
  output logic          vack,
  input  logic          creq,
  input  logic          cwr,
  input  logic [AW-1:0] ca,
  input  logic [7:0]    cd,
  output logic          cack,
  input  logic          lreq,
  input  logic          lwr,
  input  logic [AW-1:0] la,
  input  logic [7:0]    ld,
  output logic          lack,
  output logic [7:0]    rq,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  output logic          ram_we,
  input  logic [7:0]    ram_q,
  output logic          busy,
  input  logic          wp
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] c_GNT_NONE = 2'd0;
  localparam logic [1:0] c_GNT_V    = 2'd1;
  localparam logic [1:0] c_GNT_C    = 2'd2;
  localparam logic [1:0] c_GNT_L    = 2'd3;
  localparam logic [1:0] c_LAT      = 2'(LATENCY);
  localparam logic [7:0] c_STARVE   = 8'(STARVE);

  state_t        r_state;
  logic [1:0]    r_gnt;
  logic [1:0]    r_cnt;
  logic [7:0]    r_starve;
  logic          r_wr;

  logic [1:0]    w_sel;
  logic [AW-1:0] w_a;
  logic [7:0]    w_d;
  logic          w_wr;
  logic          w_block;
  logic          w_any;

  assign w_any = vreq | creq | lreq;

  // A starved loader outranks everyone; otherwise it only wins when alone.
  always_comb begin
    w_sel = c_GNT_NONE;
    w_a   = '0;
    w_d   = 8'h00;
    w_wr  = 1'b0;
    if (lreq && ((r_starve == c_STARVE) || (!vreq && !creq))) begin
      w_sel = c_GNT_L;
      w_a   = la;
      w_d   = ld;
      w_wr  = lwr;
    end else if (vreq) begin
      w_sel = c_GNT_V;
      w_a   = va;
    end else if (creq) begin
      w_sel = c_GNT_C;
      w_a   = ca;
      w_d   = cd;
      w_wr  = cwr;
    end
  end

`ifdef ARB_WP_EN
  assign w_block = (w_sel == c_GNT_C) && cwr && wp && (ca < WP_TOP);
`else
  logic w_unused_wp;
  assign w_unused_wp = wp;
  assign w_block     = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_gnt    <= c_GNT_NONE;
      r_cnt    <= 2'd0;
      r_starve <= 8'd0;
      r_wr     <= 1'b0;
      vack     <= 1'b0;
      cack     <= 1'b0;
      lack     <= 1'b0;
      rq       <= 8'h00;
      ram_a    <= '0;
      ram_d    <= 8'h00;
      ram_we   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      vack <= 1'b0;
      cack <= 1'b0;
      lack <= 1'b0;
      case (r_state)
        S_ACCESS: begin
          ram_we <= 1'b1;
          if (r_cnt == c_LAT) begin
            r_state <= S_DONE;
            if (!r_wr) rq <= ram_q;
            vack <= (r_gnt == c_GNT_V);
            cack <= (r_gnt == c_GNT_C);
            lack <= (r_gnt == c_GNT_L);
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: begin
          // IDLE and DONE both arbitrate, giving back-to-back grants.
          r_state <= S_IDLE;
          r_gnt   <= c_GNT_NONE;
          busy    <= 1'b0;
          if (!lreq || (w_sel == c_GNT_L)) begin
            r_starve <= 8'd0;
          end else if (r_starve != c_STARVE) begin
            r_starve <= r_starve + 8'd1;
          end
          if (w_any) begin
            r_state <= S_ACCESS;
            r_gnt   <= w_sel;
            r_cnt   <= 2'd0;
            r_wr    <= w_wr;
            ram_a   <= w_a;
            ram_d   <= w_d;
            ram_we  <= ~(w_wr & ~w_block);
            busy    <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter (LATENCY 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 18;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          vreq, creq, cwr, lreq, lwr, wp;
  logic [AW-1:0] va, ca, la;
  logic [7:0]    cd, ld, ram_q;
  logic          vack, cack, lack, ram_we, busy;
  logic [7:0]    rq, ram_d;
  logic [AW-1:0] ram_a;

  logic          creq3, cwr3;
  logic [AW-1:0] ca3;
  logic [7:0]    cd3, ram_q3;
  logic          vack3, cack3, lack3, ram_we3, busy3;
  logic [7:0]    rq3, ram_d3;
  logic [AW-1:0] ram_a3;
  logic          zb  = 1'b0;
  logic [AW-1:0] za  = '0;
  logic [7:0]    zd  = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ARB_WP_EN
  localparam int WP_WE_LOW = 0;
`else
  localparam int WP_WE_LOW = 1;
`endif

  mem_arbiter #(.AW(AW), .LATENCY(1), .STARVE(4)) u0 (
    .clock(clock), .reset(reset),
    .vreq(vreq), .va(va), .vack(vack),
    .creq(creq), .cwr(cwr), .ca(ca), .cd(cd), .cack(cack),
    .lreq(lreq), .lwr(lwr), .la(la), .ld(ld), .lack(lack),
    .rq(rq), .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .busy(busy), .wp(wp)
  );

  mem_arbiter #(.AW(AW), .LATENCY(3), .STARVE(4)) u3 (
    .clock(clock), .reset(reset),
    .vreq(zb), .va(za), .vack(vack3),
    .creq(creq3), .cwr(cwr3), .ca(ca3), .cd(cd3), .cack(cack3),
    .lreq(zb), .lwr(zb), .la(za), .ld(zd), .lack(lack3),
    .rq(rq3), .ram_a(ram_a3), .ram_d(ram_d3), .ram_we(ram_we3), .ram_q(ram_q3),
    .busy(busy3), .wp(zb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      tick();
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // One CPU transfer on u0; returns number of sampled cycles with ram_we low.
  task automatic cpu_xfer(input string tag, input logic wr, input logic [AW-1:0] a,
                          input logic [7:0] d, output int zc);
    zc   = 0;
    cwr  = wr;
    ca   = a;
    cd   = d;
    creq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!ram_we) zc++;
      if (i == 2) begin
        check({tag, "_cack"}, 32'(cack), 32'd1);
        creq = 1'b0;
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset && (vack | cack | lack))
      check("ack_overlap", ($countones({vack, cack, lack}) > 1) ? 32'd1 : 32'd0, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tv, tc, tl, we_cnt, we_at, lat, nv, zc;

    vreq = 0; creq = 0; cwr = 0; lreq = 0; lwr = 0; wp = 0;
    va = '0; ca = '0; la = '0; cd = 8'h00; ld = 8'h00; ram_q = 8'h00;
    creq3 = 0; cwr3 = 0; ca3 = '0; cd3 = 8'h00; ram_q3 = 8'hEE;

    #12;
    check("rst_ram_we", 32'(ram_we), 32'd1);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_acks",   32'({vack, cack, lack}), 32'd0);
    check("rst_rq",     32'(rq),     32'h00);
    check("rst_ram_a",  32'(ram_a),  32'h0);
    check("rst_ram_d",  32'(ram_d),  32'h00);
    check("rst3_ram_we", 32'(ram_we3), 32'd1);

    // Single CPU read right after reset release
    ca = 18'h14000; cwr = 0; ram_q = 8'hA5; creq = 1;
    #10 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_ram_we", 32'(ram_we), 32'd1);
      check("t1_cack", 32'(cack), (i == 2) ? 32'd1 : 32'd0);
      if (i <= 2) check("t1_ram_a", 32'(ram_a), 32'h14000);
      if (i == 0) check("t1_busy_on", 32'(busy), 32'd1);
      if (i == 1) check("t1_rq_early", 32'(rq), 32'h00);
      if (i == 2) begin
        check("t1_rq", 32'(rq), 32'hA5);
        creq = 0;
      end
      if (i == 3) check("t1_busy_off", 32'(busy), 32'd0);
    end

    // Simultaneous requests: video, CPU, loader, 3 cycles apart
    va = 18'h00010; ca = 18'h00020; la = 18'h00030; ram_q = 8'h5A;
    cwr = 0; lwr = 0;
    vreq = 1; creq = 1; lreq = 1;
    tv = -1; tc = -1; tl = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (vack) begin tv = i; check("t2_va", 32'(ram_a), 32'h10); vreq = 0; end
      if (cack) begin tc = i; check("t2_ca", 32'(ram_a), 32'h20); creq = 0; end
      if (lack) begin
        tl = i;
        check("t2_la", 32'(ram_a), 32'h30);
        check("t2_rq", 32'(rq), 32'h5A);
        lreq = 0;
      end
    end
    check("t2_vack_at", 32'(tv), 32'd2);
    check("t2_cack_at", 32'(tc), 32'd5);
    check("t2_lack_at", 32'(tl), 32'd8);

    // Loader starvation with STARVE=4
    lwr = 1; ld = 8'h3C; vreq = 1; creq = 1; lreq = 1;
    we_cnt = 0; we_at = -1; lat = -1; nv = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (!ram_we) begin
        we_cnt++;
        we_at = i;
        check("t3_ram_d", 32'(ram_d), 32'h3C);
        check("t3_ram_a", 32'(ram_a), 32'h30);
      end
      if (i == 9) check("t3_starve_sat", 32'(u0.r_starve), 32'd4);
      if (vack && lat < 0) nv++;
      if (lack) begin
        lat = i;
        lreq = 0;
        check("t3_starve_clr", 32'(u0.r_starve), 32'd0);
      end
    end
    check("t3_we_cnt", 32'(we_cnt), 32'd1);
    check("t3_we_at",  32'(we_at),  32'd12);
    check("t3_lack_at", 32'(lat), 32'd14);
    check("t3_vack_cnt", 32'(nv), 32'd4);
    vreq = 0; creq = 0; lwr = 0;
    wait_idle("t3_idle");
    tick();

    // Asynchronous reset in the middle of a CPU write
    cwr = 1; ca = 18'h00200; cd = 8'h55; creq = 1;
    tick();
    check("t4_we_low", 32'(ram_we), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("t4_we_async", 32'(ram_we), 32'd1);
    check("t4_busy_async", 32'(busy), 32'd0);
    cwr = 0; ca = 18'h14000; ram_q = 8'hC3;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_no_cack", 32'(cack), 32'd0);
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_cack", 32'(cack), (i == 2) ? 32'd1 : 32'd0);
      if (i == 0) check("t4_busy_on", 32'(busy), 32'd1);
      if (i == 2) begin
        check("t4_rq", 32'(rq), 32'hC3);
        creq = 0;
      end
      if (i == 3) check("t4_busy_off", 32'(busy), 32'd0);
    end

    // Write-protect window
    wp = 1;
    cpu_xfer("t5_prot", 1'b1, 18'h00100, 8'h77, zc);
    check("t5_prot_we", 32'(zc), 32'(WP_WE_LOW));
    cpu_xfer("t5_edge", 1'b1, 18'h04000, 8'h78, zc);
    check("t5_edge_we", 32'(zc), 32'd1);
    wp = 0;
    cwr = 0;

    // LATENCY=3 read with ram_q changing every cycle
    ca3 = 18'h2ABCD; cwr3 = 0; creq3 = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t6_cack", 32'(cack3), (i == 4) ? 32'd1 : 32'd0);
      if (i <= 4) check("t6_ram_a", 32'(ram_a3), 32'h2ABCD);
      if (i == 3) check("t6_rq_early", 32'(rq3), 32'h00);
      if (i == 4) begin
        check("t6_rq", 32'(rq3), 32'h13);
        creq3 = 0;
      end
      if (i == 5) check("t6_busy_off", 32'(busy3), 32'd0);
      ram_q3 = 8'h10 + 8'(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
